// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the I/D cacheline memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int LINE_OFS_W = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin selector, one-hot grant (bit0 = I, bit1 = D)
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req == 2'b11) begin
      // On a tie the requester that did not win last time takes the grant
      o_grant = (i_last == REQ_D) ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I-cache and D-cache line requests onto one line adapter
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  input  logic [ADDR_W-1:0] m_raddr,
  output logic              addr_err
);

  state_t              r_state;
  req_id_t             r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_addr_err;

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_busy;
  logic                w_unused_lsbs;

  assign w_req         = {d_read | d_write, i_read};
  assign w_unused_lsbs = ^{i_addr[LINE_OFS_W-1:0], d_addr[LINE_OFS_W-1:0]};

  rr_arbiter2 u_rr (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= REQ_I;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant[1]) begin
            r_state <= GRANT_D;
            r_last  <= REQ_D;
            r_addr  <= {d_addr[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
            r_write <= d_write;
            r_wdata <= d_wdata;
          end else if (w_grant[0]) begin
            r_state <= GRANT_I;
            r_last  <= REQ_I;
            r_addr  <= {i_addr[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
            r_write <= 1'b0;
            r_wdata <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (m_resp) begin
            r_state <= IDLE;
            // Response is delivered anyway; a wrong read line only raises the sticky flag
            if (!r_write && (m_raddr != r_addr)) begin
              r_addr_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy   = (r_state != IDLE);
  assign m_addr   = w_busy ? r_addr  : '0;
  assign m_wdata  = w_busy ? r_wdata : '0;
  assign m_read   = w_busy & ~r_write;
  assign m_write  = w_busy & r_write;

  assign i_resp   = (r_state == GRANT_I) & m_resp;
  assign d_resp   = (r_state == GRANT_D) & m_resp;
  assign i_rdata  = i_resp ? m_rdata : '0;
  assign d_rdata  = d_resp ? m_rdata : '0;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  m_addr;
  logic         m_read;
  logic         m_write;
  logic [255:0] m_wdata;
  logic [255:0] m_rdata;
  logic         m_resp;
  logic [31:0]  m_raddr;
  logic         addr_err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_addr   (i_addr),
    .i_read   (i_read),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_addr   (d_addr),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .m_addr   (m_addr),
    .m_read   (m_read),
    .m_write  (m_write),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_resp   (m_resp),
    .m_raddr  (m_raddr),
    .addr_err (addr_err)
  );

  typedef struct {
    logic         who;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int           lat;
    logic [31:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic         who;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic hold  = 1'b0;
  vec_t vecs[6];
  int   cyc;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic who, input logic wr, input logic [31:0] a, input logic [255:0] wd);
    exp_t e;
    e.who = who; e.wr = wr; e.addr = a; e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    if (v.who) begin
      d_addr = v.addr; d_read = v.rd; d_write = v.wr; d_wdata = v.wdata;
      push(1'b1, v.wr, v.exp_addr, v.wdata);
    end else begin
      i_addr = v.addr; i_read = 1'b1; d_wdata = '0;
      push(1'b0, 1'b0, v.exp_addr, 256'h0);
    end
  endtask

  // Plays the line adapter: waits for a grant, checks it against the scoreboard, then responds
  task automatic serve(input logic [255:0] rdata, input logic mis, input int lat, output int cycles);
    exp_t e;
    logic got;
    got = 1'b0;
    cycles = 0;
    while (cycles < 10 && !got) begin
      @(negedge clk);
      cycles++;
      got = m_read | m_write;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL grant_timeout: got no grant want grant within 10 cycles");
      return;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: got unexpected grant addr %h want none", m_addr);
      return;
    end
    e = sb.pop_front();
    if (!hold) begin
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    chk("m_addr", m_addr, e.addr);
    chk("m_write", m_write, e.wr);
    chk("m_read", m_read, !e.wr);
    chk("m_wdata", m_wdata, e.wdata);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("hold_op", {m_read, m_write}, e.wr ? 2'b01 : 2'b10);
      chk("hold_addr", m_addr, e.addr);
      chk("hold_wdata", m_wdata, e.wdata);
    end
    m_resp  = 1'b1;
    m_rdata = rdata;
    m_raddr = mis ? e.addr + 32'h20 : e.addr;
    #1;
    chk("resp_op", {m_read, m_write}, e.wr ? 2'b01 : 2'b10);
    chk("i_resp", i_resp, e.who == 1'b0);
    chk("d_resp", d_resp, e.who == 1'b1);
    chk("i_rdata", i_rdata, e.who ? 256'h0 : rdata);
    chk("d_rdata", d_rdata, e.who ? rdata : 256'h0);
    @(negedge clk);
    m_resp = 1'b0; m_rdata = '0; m_raddr = '0;
    chk("idle_gap", {m_read, m_write, i_resp, d_resp}, 4'b0);
    chk("idle_addr", m_addr, 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h2000_003F, 256'h0, {8{32'h1234_5678}}, 2, 32'h2000_0020};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h3000_0001, {32{8'hA5}}, 256'h0, 3, 32'h3000_0000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4000_0044, {8{32'hDEAD_BEEF}}, 256'h0, 0, 32'h4000_0040};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, {256{1'b1}}, 256'h0, 1, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h1000_0014, 256'h0, {4{64'h0123_4567_89AB_CDEF}}, 1, 32'h1000_0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 256'h0, {16{16'hC3C3}}, 0, 32'hFFFF_FFE0};

    rst = 1'b1;
    i_addr = '0; i_read = 1'b1; d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    m_resp = 1'b1; m_rdata = {256{1'b1}}; m_raddr = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_op", {m_read, m_write}, 2'b00);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_i_rdata", i_rdata, 256'h0);
    chk("rst_addr_err", addr_err, 1'b0);
    i_read = 1'b0; m_resp = 1'b0; m_rdata = '0;
    @(negedge clk);
    rst = 1'b0;

    // Tie straight out of reset: D first, then I after one idle cycle
    @(negedge clk);
    i_read = 1'b1; i_addr = 32'h1000_0040; d_read = 1'b1; d_addr = 32'h2000_0080;
    push(1'b1, 1'b0, 32'h2000_0080, 256'h0);
    push(1'b0, 1'b0, 32'h1000_0040, 256'h0);
    hold = 1'b1;
    serve({8{32'hAAAA_0001}}, 1'b0, 1, cyc);
    chk("tie_first_latency", cyc, 1);
    hold = 1'b0;
    serve({8{32'hAAAA_0002}}, 1'b0, 1, cyc);
    chk("tie_second_latency", cyc, 1);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      serve(vecs[i].rdata, 1'b0, vecs[i].lat, cyc);
      chk("vec_latency", cyc, 1);
    end
    chk("no_addr_err", addr_err, 1'b0);

    // Both held: alternation D,I,D,I,D,I (I won last)
    @(negedge clk);
    i_read = 1'b1; i_addr = 32'h1111_1100; d_read = 1'b1; d_addr = 32'h2222_2200; d_wdata = '0;
    for (int k = 0; k < 6; k++) begin
      if (k[0]) push(1'b0, 1'b0, 32'h1111_1100, 256'h0);
      else      push(1'b1, 1'b0, 32'h2222_2200, 256'h0);
    end
    hold = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) hold = 1'b0;
      serve({8{32'h5000_0000 + k}}, 1'b0, 1, cyc);
      chk("rr_latency", cyc, 1);
    end

    // Mismatched read address: response still delivered, flag sticks
    @(negedge clk);
    d_read = 1'b1; d_addr = 32'h2000_0000;
    push(1'b1, 1'b0, 32'h2000_0000, 256'h0);
    serve({8{32'h0BAD_0ADD}}, 1'b1, 1, cyc);
    chk("addr_err_set", addr_err, 1'b1);
    @(negedge clk);
    i_read = 1'b1; i_addr = 32'h1000_0100;
    push(1'b0, 1'b0, 32'h1000_0100, 256'h0);
    serve({8{32'h600D_600D}}, 1'b0, 0, cyc);
    chk("addr_err_sticky", addr_err, 1'b1);

    // Asynchronous reset in the middle of a D grant
    @(negedge clk);
    d_read = 1'b1; d_addr = 32'h5000_0000;
    @(negedge clk);
    chk("pre_rst_grant", m_read, 1'b1);
    #2;
    rst = 1'b1; m_resp = 1'b1; m_rdata = {8{32'hFEED_FACE}}; m_raddr = 32'h5000_0000;
    #1;
    chk("midrst_m_op", {m_read, m_write}, 2'b00);
    chk("midrst_m_addr", m_addr, 32'h0);
    chk("midrst_d_resp", d_resp, 1'b0);
    chk("midrst_d_rdata", d_rdata, 256'h0);
    chk("midrst_addr_err", addr_err, 1'b0);
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_resp = 1'b0; m_rdata = '0; m_raddr = '0;
    @(negedge clk);
    chk("post_rst_idle", {m_read, m_write, d_resp, i_resp}, 4'b0);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
